// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } stateT;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_WIDTH     = 32;

    // Returns the bit sitting at the output end of a width-bit word.
    function automatic logic bitSel(input logic [MAX_WIDTH-1:0] word,
                                    input int width,
                                    input logic msbFirst);
        logic [MAX_WIDTH-1:0] aligned;
        aligned = word >> (width - 1);
        return msbFirst ? aligned[0] : word[0];
    endfunction

endpackage

// File: rtl/piso_hold_buffer.sv
// One-entry holding register that lets the next word wait while a frame shifts out.
module piso_hold_buffer
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic [WIDTH-1:0] writeData,
    input  logic             read,
    output logic [WIDTH-1:0] readData,
    output logic             full
);

    logic [WIDTH-1:0] data;

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
        end else begin
            full <= write | (full & ~read);
        end
    end

    // Contents are only meaningful while full is set, so they need no reset.
    always_ff @(posedge clk) begin
        if (write) begin
            data <= writeData;
        end
    end

    assign readData = data;

endmodule

// File: rtl/piso_transmitter.sv
// Parallel-in, serial-out transmitter with a ready/load handshake and gapless back-to-back frames.
module piso_transmitter
    import piso_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallelIn,
    input  logic             load,
    output logic             ready,
    output logic             serialOut,
    output logic             serialValid,
    output logic             busy,
    output logic             frameEnd
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    stateT            state, stateNext;
    logic [CNT_W-1:0] bitCnt, bitCntNext;
    logic [WIDTH-1:0] shiftReg, shiftNext, shifted, bufData;
    logic             bufFull, bufWrite, bufRead, accept, lastBit;

    assign ready    = !bufFull;
    assign accept   = load && ready;
    assign lastBit  = (state == SHIFT) && (bitCnt == LAST_CNT);
    // A word accepted on the last bit goes straight into the shifter, not the buffer.
    assign bufWrite = accept && (state == SHIFT) && !lastBit;
    assign bufRead  = lastBit && bufFull;
    assign shifted  = MSB_FIRST ? {shiftReg[WIDTH-2:0], 1'b0} : {1'b0, shiftReg[WIDTH-1:1]};

    piso_hold_buffer #(.WIDTH(WIDTH)) holdBuffer (
        .clk       (clk),
        .reset     (reset),
        .write     (bufWrite),
        .writeData (parallelIn),
        .read      (bufRead),
        .readData  (bufData),
        .full      (bufFull)
    );

    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        shiftNext  = shiftReg;
        case (state)
            IDLE: begin
                if (accept) begin
                    shiftNext  = parallelIn;
                    bitCntNext = '0;
                    stateNext  = SHIFT;
                end
            end
            SHIFT: begin
                if (!lastBit) begin
                    shiftNext  = shifted;
                    bitCntNext = bitCnt + 1'b1;
                end else if (bufFull) begin
                    shiftNext  = bufData;
                    bitCntNext = '0;
                end else if (accept) begin
                    shiftNext  = parallelIn;
                    bitCntNext = '0;
                end else begin
                    shiftNext  = shifted;
                    bitCntNext = '0;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bitCnt   <= '0;
            shiftReg <= '0;
        end else begin
            state    <= stateNext;
            bitCnt   <= bitCntNext;
            shiftReg <= shiftNext;
        end
    end

    assign serialValid = (state == SHIFT);
    assign busy        = (state == SHIFT);
    assign frameEnd    = lastBit;
    assign serialOut   = (state == SHIFT) ? bitSel(MAX_WIDTH'(shiftReg), WIDTH, MSB_FIRST)
                                          : IDLE_LEVEL;

endmodule

// File: tb/tb_piso_transmitter.sv
// Self-checking bench: an MSB-first and an LSB-first transmitter against a bit-queue model.
module tb_piso_transmitter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] parallelIn;

    logic readyA, serialOutA, serialValidA, busyA, frameEndA;
    logic readyB, serialOutB, serialValidB, busyB, frameEndB;

    int errors = 0;
    int checks = 0;

    // Model: queue of pending {lastFlag, bit}; the front is what is on the wire this cycle.
    logic [1:0] qA[$];
    logic [1:0] qB[$];
    logic       accM;
    logic       modelOn = 1'b0;

    logic capA[$];
    logic capB[$];
    int   feA[$];
    int   feB[$];

    always #5 clk = ~clk;

    piso_transmitter #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dutA (
        .clk         (clk),
        .reset       (reset),
        .parallelIn  (parallelIn),
        .load        (load),
        .ready       (readyA),
        .serialOut   (serialOutA),
        .serialValid (serialValidA),
        .busy        (busyA),
        .frameEnd    (frameEndA)
    );

    piso_transmitter #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dutB (
        .clk         (clk),
        .reset       (reset),
        .parallelIn  (parallelIn),
        .load        (load),
        .ready       (readyB),
        .serialOut   (serialOutB),
        .serialValid (serialValidB),
        .busy        (busyB),
        .frameEnd    (frameEndB)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmpDut(input string tag, input int qsize, input logic [1:0] front,
                          input logic idleLvl, input logic rdy, input logic so,
                          input logic sv, input logic bz, input logic fe);
        logic v;
        v = (qsize > 0);
        chk({tag, "_ready"},       rdy, 32'(qsize <= W));
        chk({tag, "_serialValid"}, sv,  32'(v));
        chk({tag, "_busy"},        bz,  32'(v));
        chk({tag, "_frameEnd"},    fe,  32'(v && front[1]));
        chk({tag, "_serialOut"},   so,  32'(v ? front[0] : idleLvl));
    endtask

    function automatic logic [31:0] packMsb(input logic q[$], input int start, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) w = {w[30:0], q[start + i]};
        return w;
    endfunction

    function automatic logic [31:0] packLsb(input logic q[$], input int start, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) w[i] = q[start + i];
        return w;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            qA.delete();
            qB.delete();
            modelOn = 1'b1;
        end else begin
            accM = load && (qA.size() <= W);
            if (qA.size() > 0) void'(qA.pop_front());
            if (qB.size() > 0) void'(qB.pop_front());
            if (accM) begin
                for (int i = 0; i < W; i++) begin
                    qA.push_back({i == W - 1, parallelIn[W - 1 - i]});
                    qB.push_back({i == W - 1, parallelIn[i]});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (modelOn) begin
            cmpDut("A", qA.size(), (qA.size() > 0) ? qA[0] : 2'b00, 1'b0,
                   readyA, serialOutA, serialValidA, busyA, frameEndA);
            cmpDut("B", qB.size(), (qB.size() > 0) ? qB[0] : 2'b00, 1'b1,
                   readyB, serialOutB, serialValidB, busyB, frameEndB);
            if (serialValidA) capA.push_back(serialOutA);
            if (frameEndA)    feA.push_back(capA.size());
            if (serialValidB) capB.push_back(serialOutB);
            if (frameEndB)    feB.push_back(capB.size());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearCap();
        capA.delete();
        capB.delete();
        feA.delete();
        feB.delete();
    endtask

    initial begin
        reset      = 1'b1;
        load       = 1'b0;
        parallelIn = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_ready", readyA, 1);
        chk("rst_valid", serialValidA, 0);
        chk("rst_busy", busyA, 0);
        chk("rst_frameEnd", frameEndA, 0);
        chk("rst_outA", serialOutA, 0);
        chk("rst_outB", serialOutB, 1);

        // Single word, MSB first
        clearCap();
        load = 1'b1; parallelIn = 8'hA5;
        chk("t1_ready", readyA, 1);
        step();
        load = 1'b0;
        repeat (10) step();
        chk("t1_nbits", capA.size(), 8);
        chk("t1_word", packMsb(capA, 0, 8), 32'hA5);
        chk("t1_fe_count", feA.size(), 1);
        chk("t1_fe_pos", (feA.size() > 0) ? feA[0] : -1, 8);
        chk("t1_idle_out", serialOutA, 0);
        chk("t1_rxB", packLsb(capB, 0, 8), 32'hA5);

        // Back-to-back through the holding buffer
        clearCap();
        load = 1'b1; parallelIn = 8'hF0;
        step();
        load = 1'b0;
        step();
        step();
        load = 1'b1; parallelIn = 8'h0F;
        step();
        load = 1'b0;
        chk("t2_ready_low", readyA, 0);
        repeat (4) step();
        chk("t2_ready_last", readyA, 0);
        step();
        chk("t2_ready_reload", readyA, 1);
        repeat (10) step();
        chk("t2_nbits", capA.size(), 16);
        chk("t2_word", packMsb(capA, 0, 16), 32'hF00F);
        chk("t2_fe_count", feA.size(), 2);
        chk("t2_fe_pos0", (feA.size() > 0) ? feA[0] : -1, 8);
        chk("t2_fe_pos1", (feA.size() > 1) ? feA[1] : -1, 16);

        // Load blocked while the buffer is full
        clearCap();
        load = 1'b1; parallelIn = 8'h55;
        step();
        load = 1'b0;
        step();
        load = 1'b1; parallelIn = 8'h66;
        step();
        load = 1'b0;
        step();
        load = 1'b1; parallelIn = 8'hFF;
        chk("t3_ready_full", readyA, 0);
        step();
        load = 1'b0;
        repeat (20) step();
        chk("t3_nbits", capA.size(), 16);
        chk("t3_word", packMsb(capA, 0, 16), 32'h5566);

        // Accept on the last bit with an empty buffer
        clearCap();
        load = 1'b1; parallelIn = 8'h3C;
        step();
        load = 1'b0;
        repeat (7) step();
        chk("t4_frameEnd", frameEndA, 1);
        load = 1'b1; parallelIn = 8'h81;
        chk("t4_ready", readyA, 1);
        step();
        load = 1'b0;
        chk("t4_gapless", serialValidA, 1);
        repeat (10) step();
        chk("t4_nbits", capA.size(), 16);
        chk("t4_word", packMsb(capA, 0, 16), 32'h3C81);
        chk("t4_fe_count", feA.size(), 2);

        // LSB-first stream and receiver reconstruction
        clearCap();
        load = 1'b1; parallelIn = 8'h01;
        step();
        load = 1'b0;
        repeat (10) step();
        chk("t5_nbitsB", capB.size(), 8);
        chk("t5_seqB", packMsb(capB, 0, 8), 32'h80);
        chk("t5_rxB", packLsb(capB, 0, 8), 32'h01);
        chk("t5_idleB", serialOutB, 1);

        // Reset mid-frame with a word buffered; load during reset is ignored
        clearCap();
        load = 1'b1; parallelIn = 8'hAA;
        step();
        load = 1'b0;
        step();
        load = 1'b1; parallelIn = 8'h55;
        step();
        load = 1'b0;
        step();
        reset = 1'b1; load = 1'b1; parallelIn = 8'hC3;
        step();
        reset = 1'b0; load = 1'b0;
        chk("t6_ready", readyA, 1);
        chk("t6_valid", serialValidA, 0);
        chk("t6_busy", busyA, 0);
        chk("t6_frameEnd", frameEndA, 0);
        chk("t6_out", serialOutA, 0);
        repeat (20) step();
        chk("t6_nbits", capA.size(), 4);
        chk("t6_partial", packMsb(capA, 0, 4), 32'hA);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            load       = ($urandom_range(0, 2) == 0);
            parallelIn = W'($urandom);
            reset      = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        load  = 1'b0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_transmitter.md
Name: piso_transmitter

Overview:
- Parallel-in, serial-out transmitter: the sending end of the team's 8-bit serial-in/parallel-out shift-register link.
- Accepts a parallel word through a ready/load handshake and shifts it out one bit per clock, qualified by a valid strobe.
- A one-entry holding buffer allows back-to-back words with no idle gap between frames.
- Sits in front of the SIPO receiver: serialOut drives the receiver's serialIn.

Parameters:
- WIDTH, 8, bits per frame; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first, 0 = bit 0 shifted first.
- IDLE_LEVEL, 0, value driven on serialOut when no bit is being sent.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising clk edge
- parallelIn  input  WIDTH  word to transmit
- load  input  1  request to transfer parallelIn; accepted only when ready=1
- ready  output  1  transmitter can accept a word this cycle
- serialOut  output  1  current serial bit
- serialValid  output  1  serialOut carries a data bit this cycle
- busy  output  1  state is SHIFT
- frameEnd  output  1  one-cycle pulse coincident with the last bit of a frame

Behaviour:
- Reset values (one cycle after reset sampled high): state=IDLE, bitCnt=0, shiftReg=0, buffer empty, ready=1, serialOut=IDLE_LEVEL, serialValid=0, busy=0, frameEnd=0.
- Reset mid-frame: aborts the frame and discards the buffer contents. A load in the same cycle as reset is ignored.
- Handshake:
  - ready = !bufFull. This is combinational from registered state only; no dependence on load.
  - Accept = load & ready; load while ready=0 is ignored.
  - parallelIn is sampled only on an accepting edge.
- FSM states: IDLE, SHIFT.
  - IDLE + accept: shiftReg <= parallelIn, bitCnt <= 0, go to SHIFT. First bit appears on serialOut the cycle after accept, so latency is 1 clock.
  - SHIFT + accept: word written to the holding buffer, bufFull <= 1.
  - SHIFT, bitCnt < WIDTH-1: shift by one toward the output end, bitCnt++.
  - SHIFT, bitCnt == WIDTH-1 (last bit):
    - frameEnd=1 this cycle.
    - Buffer full: reload shiftReg from the buffer, bufFull <= 0, bitCnt <= 0, stay in SHIFT. The next frame's first bit follows on the very next cycle, with no gap.
    - Buffer empty and accept this cycle: load parallelIn directly into shiftReg, stay in SHIFT (gapless).
    - Buffer empty and no accept: go to IDLE.
- serialOut:
  - In SHIFT: shiftReg[WIDTH-1] if MSB_FIRST, else shiftReg[0].
  - In IDLE: IDLE_LEVEL.
- serialValid = busy = (state==SHIFT).
- Vacated shift positions fill with 0.
- Frame length is exactly WIDTH cycles of serialValid=1. Back-to-back frames give continuous serialValid with a frameEnd pulse every WIDTH cycles.
- bitCnt width is $clog2(WIDTH). The counter never wraps except by the explicit reload to 0.

Decomposition:
- Package piso_pkg holds:
  - the state enum type (IDLE, SHIFT);
  - the default width constant (8);
  - helper function bitSel(word, msbFirst) returning the output-end bit.
- Natural sub-module: piso_hold_buffer, a one-entry register with write/read/full. It is instantiated once; the FSM, counter and shifter stay in the top.

Test Plan:
- Reset then single word: load=1 with parallelIn=8'hA5, MSB_FIRST=1.
  - Expect ready=1 at the accept edge.
  - Expect serialOut sequence 1,0,1,0,0,1,0,1 on the following 8 cycles with serialValid=1.
  - Expect frameEnd high only on the 8th bit, then IDLE with serialOut=0.
- Back-to-back: accept 8'hF0, then accept 8'h0F during bit 3.
  - Expect ready=0 after that accept until the reload.
  - Expect 16 consecutive valid bits 11110000 00001111 and frameEnd at bits 8 and 16.
- Blocked load: with the buffer full, pulse load with 8'hFF.
  - Expect it ignored: the output stream is unchanged and 8'hFF is never transmitted.
- Last-bit accept with empty buffer: accept 8'h81 exactly on the frameEnd cycle of 8'h3C.
  - Expect continuous stream 00111100 10000001 with no gap.
- LSB-first: MSB_FIRST=0, send 8'h01.
  - Expect serialOut 1,0,0,0,0,0,0,0.
  - Loop serialOut into the SIPO receiver and check that its parallel output reconstructs the word after 8 clocks.
- Reset mid-frame: assert reset during bit 4 of 8'hAA with 8'h55 buffered.
  - Expect all outputs at reset values the next cycle.
  - Expect ready=1 and no further valid bits; 8'h55 is never sent.
